// File: rtl/scene_sequencer_if.sv
// scene_sequencer_if: control/status bundle between the VGA timing/UI logic and the scene sequencer
interface scene_sequencer_if;
    logic       frame_start;
    logic       step_btn;
    logic       auto_en;
    logic [3:0] dwell;
    logic [1:0] scene_id;
    logic       twinkle_en;
    logic       horizon_en;
    logic       invert_en;
    logic [2:0] glow_level;
    logic       step_ack;

    modport master (
        output frame_start, step_btn, auto_en, dwell,
        input  scene_id, twinkle_en, horizon_en, invert_en, glow_level, step_ack
    );

    modport slave (
        input  frame_start, step_btn, auto_en, dwell,
        output scene_id, twinkle_en, horizon_en, invert_en, glow_level, step_ack
    );
endinterface

// File: rtl/scene_sequencer.sv
// scene_sequencer: debounced/auto scene stepping on frame boundaries; SCENE_GLOW_RAMP_EN selects ramped glow
module scene_sequencer #(
    parameter int DB_CYCLES = 16
) (
    input logic              clk,
    input logic              rst_n,
    scene_sequencer_if.slave seq_if
);
    localparam logic [1:0] SPACE   = 2'd0;
    localparam logic [1:0] TWINKLE = 2'd1;
    localparam logic [1:0] DAWN    = 2'd2;
    localparam logic [1:0] NEBULA  = 2'd3;

    logic        sync1_q, sync2_q;
    logic        db_q, db_d;
    logic [15:0] db_cnt_q, db_cnt_d;
    logic        db_accept;
    logic        step_ack_q, step_ack_d;
    logic        pending_q, pending_d;
    logic [5:0]  fc_q, fc_d;
    logic [1:0]  scene_q, scene_d;
    logic        twinkle_q, twinkle_d;
    logic        horizon_q, horizon_d;
    logic        invert_q, invert_d;
    logic [2:0]  glow_q, glow_d;
    logic        expiry, advance;

    // Two-flop synchronizer for the raw pushbutton
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= seq_if.step_btn;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: a new level is taken once DB_CYCLES samples in a row differ from the current one
    always_comb begin
        db_accept  = (sync2_q != db_q) && (db_cnt_q == 16'(DB_CYCLES - 1));
        db_cnt_d   = (sync2_q == db_q || db_accept) ? 16'd0 : db_cnt_q + 16'd1;
        db_d       = db_accept ? sync2_q : db_q;
        step_ack_d = db_accept & sync2_q;
    end

    // Scene advance only on frame_start; an ack arriving with frame_start lands in pending after the clear
    always_comb begin
        expiry    = seq_if.auto_en && (fc_q == {seq_if.dwell, 2'b11});
        advance   = seq_if.frame_start && (pending_q || expiry);
        pending_d = step_ack_q || (pending_q && !advance);
        fc_d      = (!seq_if.auto_en || advance) ? 6'd0 : seq_if.frame_start ? fc_q + 6'd1 : fc_q;
        scene_d   = advance ? scene_q + 2'd1 : scene_q;
        twinkle_d = scene_d != SPACE;
        horizon_d = scene_d == DAWN || scene_d == NEBULA;
        invert_d  = scene_d == NEBULA;
`ifdef SCENE_GLOW_RAMP_EN
        glow_d    = !seq_if.frame_start ? glow_q :
                    (advance && scene_d != NEBULA) ? 3'd0 :
                    (scene_q != DAWN && scene_q != NEBULA) ? 3'd0 :
                    (glow_q == 3'd7) ? 3'd7 : glow_q + 3'd1;
`else
        glow_d    = horizon_d ? 3'd7 : 3'd0;
`endif
    end

    // Debouncer and step pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q       <= 1'b0;
            db_cnt_q   <= 16'd0;
            step_ack_q <= 1'b0;
        end else begin
            db_q       <= db_d;
            db_cnt_q   <= db_cnt_d;
            step_ack_q <= step_ack_d;
        end
    end

    // Scene state, dwell counter and registered scene outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            fc_q      <= 6'd0;
            scene_q   <= SPACE;
            twinkle_q <= 1'b0;
            horizon_q <= 1'b0;
            invert_q  <= 1'b0;
            glow_q    <= 3'd0;
        end else begin
            pending_q <= pending_d;
            fc_q      <= fc_d;
            scene_q   <= scene_d;
            twinkle_q <= twinkle_d;
            horizon_q <= horizon_d;
            invert_q  <= invert_d;
            glow_q    <= glow_d;
        end
    end

    assign seq_if.scene_id   = scene_q;
    assign seq_if.twinkle_en = twinkle_q;
    assign seq_if.horizon_en = horizon_q;
    assign seq_if.invert_en  = invert_q;
    assign seq_if.glow_level = glow_q;
    assign seq_if.step_ack   = step_ack_q;
endmodule

// File: doc/scene_sequencer.md
SCENE_SEQUENCER -- requirements
Module: scene_sequencer

Interface
REQ-001 Parameter DB_CYCLES, default 16, is the number of consecutive stable synchronized samples required to accept a new step_btn level, with a valid range of 2 to 65535.
REQ-002 Port clk, input, 1 bit, is the single pixel clock that drives all state.
REQ-003 Port rst_n, input, 1 bit, is an asynchronous active-low reset.
REQ-004 Port frame_start, input, 1 bit, is a one-cycle pulse from the VGA timing logic at hcount=799, vcount=524.
REQ-005 Port step_btn, input, 1 bit, is a raw asynchronous pushbutton, active-high.
REQ-006 Port auto_en, input, 1 bit, enables automatic scene advance when high.
REQ-007 Port dwell, input, 4 bits, sets the automatic dwell time in units of 4 frames.
REQ-008 Port scene_id, output, 2 bits, is the current scene: 0=SPACE, 1=TWINKLE, 2=DAWN, 3=NEBULA.
REQ-009 Port twinkle_en, output, 1 bit, is the star twinkle enable.
REQ-010 Port horizon_en, output, 1 bit, is the horizon glow enable.
REQ-011 Port invert_en, output, 1 bit, is the nebula colour invert enable.
REQ-012 Port glow_level, output, 3 bits, is the horizon glow intensity.
REQ-013 Port step_ack, output, 1 bit, is a one-cycle pulse on each debounced step_btn rising edge.

Function
REQ-014 step_btn shall pass through a 2-flop synchronizer, then through a debouncer that accepts a new level only after DB_CYCLES consecutive identical synchronized samples.
REQ-015 A rising edge of the debounced level shall assert step_ack for exactly 1 cycle and set a pending flag.
REQ-016 The FSM order shall be SPACE -> TWINKLE -> DAWN -> NEBULA -> SPACE, and NEBULA shall wrap to SPACE.
REQ-017 The FSM shall advance only in a cycle where frame_start=1 and either pending=1 or the auto-expiry condition is true.
REQ-018 The outputs shall not change mid-frame.
REQ-019 A 6-bit frame counter shall increment on each frame_start while auto_en=1, and shall be held at 0 while auto_en=0.
REQ-020 Auto-expiry shall be true when auto_en=1 and the frame counter equals {dwell,2'b11}, giving (dwell+1)*4 frames per scene.
REQ-021 When dwell=0, the dwell time shall be 4 frames.
REQ-022 On any advance, the frame counter and the pending flag shall both clear.
REQ-023 If a manual step and auto-expiry coincide on the same frame_start, the FSM shall advance exactly one scene.
REQ-024 Multiple step_ack pulses within one frame shall produce only one advance, with no queueing.
REQ-025 A step_ack in the same cycle as frame_start shall be counted toward the next frame_start, not the current one.
REQ-026 All outputs shall be registered, and scene_id, twinkle_en, horizon_en and invert_en shall update in the cycle after the advancing frame_start (latency 1).
REQ-027 The scene decode for twinkle_en/horizon_en/invert_en shall be SPACE=0/0/0, TWINKLE=1/0/0, DAWN=1/1/0, NEBULA=1/1/1.
REQ-028 Deasserting auto_en mid-dwell shall clear the frame counter, and re-asserting it shall restart the full dwell period.
REQ-029 A change of dwell mid-dwell shall take effect at the next compare, and if the counter has already passed the new target, advance shall occur only after the counter wraps at 63 back to the target.

Reset
REQ-030 While rst_n=0, scene shall be SPACE, scene_id=0, twinkle_en=0, horizon_en=0, invert_en=0, glow_level=0, step_ack=0, pending=0, frame counter=0, debounced level=0, and synchronizer flops=0.
REQ-031 Reset asserted mid-operation shall abandon any pending step and any dwell in progress, with no advance on release.
REQ-032 The first scene change after reset shall require a new frame_start.

Configuration
REQ-033 Macro SCENE_GLOW_RAMP_EN shall select the glow_level behaviour.
REQ-034 With SCENE_GLOW_RAMP_EN defined, entering DAWN shall load glow_level=0.
REQ-035 With SCENE_GLOW_RAMP_EN defined, glow_level shall then increment by 1 on each frame_start while in DAWN or NEBULA, saturating at 7.
REQ-036 With SCENE_GLOW_RAMP_EN defined, entering SPACE shall load glow_level=0, and glow_level shall hold at 0 through TWINKLE.
REQ-037 Without SCENE_GLOW_RAMP_EN, glow_level shall be 7 when horizon_en=1 and 0 otherwise, registered with the same latency as horizon_en.

Verification
REQ-038 With DB_CYCLES=4 and auto_en=0, a step_btn pulse 10 cycles wide followed by frame_start shall give 1 step_ack, and scene_id shall go 0->1 and twinkle_en=1 one cycle after frame_start.
REQ-039 A step_btn glitch of 2 cycles shall produce no step_ack and no advance, and scene_id shall stay 0.
REQ-040 With auto_en=1 and dwell=1, scene_id shall advance every 8 frame_start pulses, and the sequence 0,1,2,3,0 shall be checked across 32 frames including the wrap.
REQ-041 With auto_en=1, dwell=0 and a step landing on the 4th frame, scene_id shall advance exactly one scene (0->1), not two.
REQ-042 Asserting rst_n=0 while pending=1 in scene 2 shall give all outputs 0 immediately, and no advance shall occur on the following frame_start.
REQ-043 With SCENE_GLOW_RAMP_EN defined, entering DAWN shall give glow_level=0, then 1..7 on successive frames, then hold at 7, then return to 0 on entering SPACE.
REQ-044 Without SCENE_GLOW_RAMP_EN, glow_level shall be 7 immediately on entering DAWN.
